// File: rtl/plate_capture.sv
// Pressure-plate front end: synchronizes and debounces the raw contacts, then commits
// one stable non-zero pattern per press. A clean release is required before re-arming.
module plate_capture #(
    parameter int WIDTH       = 8,
    parameter int DEBOUNCE    = 16,
    parameter int RELEASE_CYC = 4,
    parameter int HOLD_MAX    = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] plate_raw,
    input  logic             enable,
    output logic [WIDTH-1:0] plate_out,
    output logic             plate_valid,
    output logic             busy,
    output logic             plate_stuck
);
    typedef enum logic [1:0] {IDLE, SETTLE, HELD, RELEASE} state_t;

    localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE - 1);
    localparam logic [15:0] REL_LAST  = 16'(RELEASE_CYC - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);

    state_t           state;
    logic [WIDTH-1:0] sync1, ps, cand;
    logic [15:0]      cnt, cnt_inc;

    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            ps    <= '0;
        end else begin
            sync1 <= plate_raw;
            ps    <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            cand        <= '0;
            plate_out   <= '0;
            plate_valid <= 1'b0;
            busy        <= 1'b0;
            plate_stuck <= 1'b0;
        end else begin
            plate_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && ps != '0) begin
                        cand  <= ps;
                        cnt   <= 16'd1;
                        state <= SETTLE;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (!enable || ps == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (ps != cand) begin
                        cand <= ps;
                        cnt  <= 16'd1;
                    end else if (cnt == DEB_LAST) begin
                        plate_out   <= cand;
                        plate_valid <= 1'b1;
                        cnt         <= '0;
                        state       <= HELD;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                HELD: begin
                    if (ps == '0) begin
                        cnt   <= 16'd1;
                        state <= RELEASE;
                    end else begin
                        // >= keeps the flag correct once the counter has saturated
                        if (cnt >= HOLD_LAST) plate_stuck <= 1'b1;
                        cnt <= cnt_inc;
                    end
                end
                RELEASE: begin
                    if (ps != '0) begin
                        cnt   <= '0;
                        state <= HELD;
                    end else if (cnt == REL_LAST || RELEASE_CYC == 1) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_plate_capture.sv
// Randomized bench for plate_capture, checked every cycle against a run-length model
// of the press/release rules.
module tb_plate_capture;
    localparam int W = 8, DB = 4, RC = 2, HM = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] plate_raw = '0;
    logic         enable = 1'b0;
    logic [W-1:0] plate_out;
    logic         plate_valid, busy, plate_stuck;

    plate_capture #(.WIDTH(W), .DEBOUNCE(DB), .RELEASE_CYC(RC), .HOLD_MAX(HM)) dut (
        .clk(clk), .reset(reset), .plate_raw(plate_raw), .enable(enable),
        .plate_out(plate_out), .plate_valid(plate_valid), .busy(busy),
        .plate_stuck(plate_stuck)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: armed = waiting for a press; run = length of the current stable
    // enabled non-zero run; hold/zlen track the held and released lengths.
    logic [W-1:0] m_s1, m_ps, m_out, runpat;
    bit           m_valid, m_stuck, armed;
    int           run, hold, zlen;

    function automatic void m_reset();
        m_s1 = '0; m_ps = '0; m_out = '0; runpat = '0;
        m_valid = 0; m_stuck = 0; armed = 1;
        run = 0; hold = 0; zlen = 0;
    endfunction

    function automatic void m_step(input logic [W-1:0] raw, input bit en);
        logic [W-1:0] p;
        p = m_ps;
        m_valid = 0;
        if (armed) begin
            if (en && p != '0) begin
                run = (run > 0 && p == runpat) ? run + 1 : 1;
                runpat = p;
                if (run == DB) begin
                    m_out = p; m_valid = 1; armed = 0;
                    hold = 0; zlen = 0; run = 0;
                end
            end else run = 0;
        end else if (p == '0) begin
            zlen++;
            if (zlen >= (RC < 2 ? 2 : RC)) begin armed = 1; run = 0; end
        end else if (zlen > 0) begin
            zlen = 0; hold = 0;
        end else begin
            if (hold >= HM - 1) m_stuck = 1;
            hold++;
        end
        m_ps = m_s1;
        m_s1 = raw;
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, ".out"},   32'(plate_out),   32'(m_out));
        chk({tag, ".valid"}, 32'(plate_valid), 32'(m_valid));
        chk({tag, ".busy"},  32'(busy),        32'(!armed || run > 0));
        chk({tag, ".stuck"}, 32'(plate_stuck), 32'(m_stuck));
    endtask

    task automatic cycle(input logic [W-1:0] r, input bit e, input string tag);
        plate_raw = r;
        enable    = e;
        @(posedge clk);
        m_step(r, e);
        @(negedge clk);
        check_outs(tag);
    endtask

    task automatic hold_pat(input logic [W-1:0] r, input int n, input bit e, input string tag);
        for (int i = 0; i < n; i++) cycle(r, e, tag);
    endtask

    // Assert reset mid-cycle, confirm the outputs clear without a clock, release at negedge
    task automatic pulse_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        m_reset();
        chk({tag, ".rst_out"},   32'(plate_out),   0);
        chk({tag, ".rst_valid"}, 32'(plate_valid), 0);
        chk({tag, ".rst_busy"},  32'(busy),        0);
        chk({tag, ".rst_stuck"}, 32'(plate_stuck), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int commits;
        logic [W-1:0] pats [4];
        m_reset();
        #1;
        chk("reset.out",   32'(plate_out),   0);
        chk("reset.valid", 32'(plate_valid), 0);
        chk("reset.busy",  32'(busy),        0);
        chk("reset.stuck", 32'(plate_stuck), 0);
        @(negedge clk);
        reset = 1'b1;

        // Clean press, with explicit latency checks on top of the model
        commits = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(8'hAA, 1'b1, "clean");
            if (i == 1) chk("clean.busy_pre_e2", 32'(busy), 0);
            if (i == 2) chk("clean.busy_e2", 32'(busy), 1);
            if (plate_valid) commits++;
            if (i == 5) chk("clean.valid_e5", 32'(plate_valid), 1);
        end
        chk("clean.commits", 32'(commits), 1);
        hold_pat(8'h00, 4, 1'b1, "clean_rel");

        // Bounce while settling
        hold_pat(8'hCC, 2, 1'b1, "bounce");
        hold_pat(8'hCD, 1, 1'b1, "bounce");
        hold_pat(8'hCC, 10, 1'b1, "bounce");
        chk("bounce.out", 32'(plate_out), 32'h0CC);
        hold_pat(8'h00, 4, 1'b1, "bounce_rel");

        // Re-arm rule
        hold_pat(8'hF0, 8, 1'b1, "rearm");
        hold_pat(8'h00, 1, 1'b1, "rearm");
        hold_pat(8'hF0, 6, 1'b1, "rearm");
        hold_pat(8'h00, 3, 1'b1, "rearm");
        hold_pat(8'h0F, 8, 1'b1, "rearm");
        chk("rearm.out", 32'(plate_out), 32'h00F);
        hold_pat(8'h00, 4, 1'b1, "rearm_rel");

        // Stuck flag, sticky across release
        hold_pat(8'hAA, 46, 1'b1, "stuck");
        chk("stuck.set", 32'(plate_stuck), 1);
        hold_pat(8'h00, 4, 1'b1, "stuck_rel");
        chk("stuck.sticky", 32'(plate_stuck), 1);

        // Enable low blocks a press
        hold_pat(8'h55, 10, 1'b0, "disabled");
        chk("disabled.busy", 32'(busy), 0);
        hold_pat(8'h00, 2, 1'b0, "disabled");

        // Reset mid-settle, then the still-held pattern is a fresh press
        hold_pat(8'h55, 4, 1'b1, "midrst");
        pulse_reset("midrst");
        hold_pat(8'h55, 10, 1'b1, "midrst_after");
        chk("midrst.out", 32'(plate_out), 32'h055);
        hold_pat(8'h00, 4, 1'b1, "midrst_rel");

        // Randomized presses drawn from a small pattern pool so runs can stabilize
        for (int i = 0; i < 4; i++) pats[i] = 8'($urandom_range(1, 255));
        for (int n = 0; n < 80; n++) begin
            logic [W-1:0] p;
            bit           e;
            p = (n % 9 == 0) ? 8'($urandom) : pats[$urandom_range(0, 3)];
            e = ($urandom_range(0, 9) != 0);
            hold_pat(p, (n % 13 == 0) ? 40 : int'($urandom_range(1, 8)), e, "rand");
            hold_pat(8'h00, int'($urandom_range(0, 4)), e, "rand_gap");
            if ($urandom_range(0, 24) == 0) pulse_reset("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/plate_capture.md
Name: plate_capture

Overview:
- Front-end stage for the vault's pressure-plate puzzle; sits directly upstream of the plate-sequence checker.
- Synchronizes and debounces raw plate inputs.
- Commits one stable non-zero pattern per press and presents it on plate_out with a one-cycle plate_valid strobe.
- Requires a clean release (all plates up) before the next press is accepted; flags plates held too long.

Parameters:
- WIDTH, 8, number of plates; width of plate_raw and plate_out.
- DEBOUNCE, 16, consecutive synchronized cycles a pattern must hold before commit; legal range 2..255.
- RELEASE_CYC, 4, consecutive all-zero synchronized cycles required to re-arm; legal range 1..255.
- HOLD_MAX, 1024, cycles in HELD before plate_stuck asserts; must be greater than DEBOUNCE.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, asynchronous active-low reset; when 0, all state clears immediately.
- plate_raw, input, WIDTH, asynchronous plate contacts; 1 = pressed.
- enable, input, 1, permits new presses to start settling.
- plate_out, output, WIDTH, last committed pattern.
- plate_valid, output, 1, one-cycle pulse; plate_out is new this cycle.
- busy, output, 1, high in any state other than IDLE.
- plate_stuck, output, 1, sticky error flag: pattern held beyond HOLD_MAX.

Behaviour:
- Reset (reset=0, async): plate_out=0, plate_valid=0, busy=0, plate_stuck=0; FSM=IDLE; counters=0; candidate=0; synchronizer flops=0.
- Synchronizer: two-flop stage on plate_raw produces ps. The FSM sees only ps.
- Counter: single cycle counter, saturating at 2^16-1, shared across SETTLE, HELD and RELEASE.
- plate_valid: registered, high for exactly one cycle per commit.
- plate_out: updates only on commit; holds its value otherwise, including across presses that are aborted.
- FSM states: IDLE, SETTLE, HELD, RELEASE. Transitions are evaluated each rising edge:
  - IDLE: if enable=1 and ps!=0, set cand<=ps, cnt<=1, go to SETTLE. Otherwise stay in IDLE.
  - SETTLE:
    - If enable=0 or ps==0, go to IDLE (abort, no commit).
    - Else if ps!=cand, set cand<=ps, cnt<=1 (restart count, stay in SETTLE).
    - Else if cnt==DEBOUNCE-1, set plate_out<=cand, plate_valid<=1, cnt<=0, go to HELD.
    - Else cnt<=cnt+1.
  - HELD:
    - If ps==0, set cnt<=1 and go to RELEASE.
    - Otherwise cnt<=cnt+1. When cnt reaches HOLD_MAX-1, plate_stuck<=1 (sticky until reset); remain in HELD.
    - Pattern changes while HELD are ignored; no new commit.
  - RELEASE:
    - If ps!=0, go to HELD (bounce). The HELD counter resumes from 0, and plate_stuck is unaffected.
    - Else if cnt==RELEASE_CYC-1 (or RELEASE_CYC==1), go to IDLE.
    - Else cnt<=cnt+1.
- enable only gates IDLE→SETTLE and aborts SETTLE. HELD and RELEASE ignore enable, so a release is always tracked.
- Latency: let edge E0 be the first rising edge that samples a new stable raw pattern, starting from IDLE with enable=1.
  - ps shows the pattern after E1.
  - SETTLE is entered at E2.
  - plate_valid is high in the cycle following edge E(DEBOUNCE+1).
- busy = (state != IDLE), registered with the state.
- Reset mid-press: immediate return to the reset values; no plate_valid is emitted. A pattern still held after reset deasserts is a fresh press.

Test Plan:
- Parameters for all scenarios: DEBOUNCE=4, RELEASE_CYC=2, HOLD_MAX=32.
- Clean press: plate_raw=0xAA held 10 cycles from E0 → single plate_valid pulse after E5, plate_out=0xAA, busy=1 from after E2.
- Bounce in SETTLE: 0xCC for 2 cycles, then 0xCD for 1 cycle, then 0xCC held → count restarts each change; exactly one commit of 0xCC, delayed accordingly; no commit of 0xCD.
- Re-arm rule: commit 0xF0; drop to 0 for 1 cycle; return 0xF0 for 6 cycles; release for 3 cycles; press 0x0F → no second 0xF0 commit; 0x0F commits once after re-arm.
- Stuck and enable:
  - Hold 0xAA for 40 cycles after commit → plate_stuck=1 at HELD cnt 31, stays 1 after release.
  - With enable=0 and press 0x55 → no commit, busy stays 0.
- Async reset mid-SETTLE (cnt=2): reset low → all outputs 0 immediately. Release reset with 0x55 still held → fresh commit 4 cycles after SETTLE entry.
